// File: rtl/hwpe_ctrl_package.sv
// Shared types and default parameters for the HWPE control microcode loop engine.
package hwpe_ctrl_package;

    typedef enum logic [1:0] {
        ULOOP_OP_MOV = 2'b00,
        ULOOP_OP_ADD = 2'b01,
        ULOOP_OP_SUB = 2'b10,
        ULOOP_OP_NOP = 2'b11
    } uloop_op_t;

    typedef enum logic [1:0] {
        ULOOP_IDLE  = 2'd0,
        ULOOP_RUN   = 2'd1,
        ULOOP_DRAIN = 2'd2
    } uloop_state_t;

    localparam int unsigned ULOOP_STREAM_NB_LOOPS   = 6;
    localparam int unsigned ULOOP_STREAM_LENGTH     = 32;
    localparam int unsigned ULOOP_STREAM_NB_REG     = 5;
    localparam int unsigned ULOOP_STREAM_NB_RO_REG  = 28;
    localparam int unsigned ULOOP_STREAM_REG_WIDTH  = 32;
    localparam int unsigned ULOOP_STREAM_CNT_WIDTH  = 16;
    localparam int unsigned ULOOP_STREAM_FIFO_DEPTH = 2;

endpackage

// File: rtl/hwpe_ctrl_uloop_rec_fifo.sv
// Record FIFO between the loop engine and the streamers; a push is accepted
// when full as long as a pop happens in the same cycle.
module hwpe_ctrl_uloop_rec_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    always_comb begin
        full_o  = (cnt_q == CNT_FULL);
        empty_o = (cnt_q == '0);
        data_o  = mem_q[rd_ptr_q];
        pop_ok  = pop_i && !empty_o;
        push_ok = push_i && (!full_o || pop_ok);
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/hwpe_ctrl_uloop_stream.sv
// Microcode loop engine: walks a loop nest, runs per-loop microcode on the
// accumulators and streams {offsets, indices, loop, last} records to a FIFO.
module hwpe_ctrl_uloop_stream
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned NB_LOOPS   = ULOOP_STREAM_NB_LOOPS,
    parameter int unsigned LENGTH     = ULOOP_STREAM_LENGTH,
    parameter int unsigned NB_REG     = ULOOP_STREAM_NB_REG,
    parameter int unsigned NB_RO_REG  = ULOOP_STREAM_NB_RO_REG,
    parameter int unsigned REG_WIDTH  = ULOOP_STREAM_REG_WIDTH,
    parameter int unsigned CNT_WIDTH  = ULOOP_STREAM_CNT_WIDTH,
    parameter int unsigned FIFO_DEPTH = ULOOP_STREAM_FIFO_DEPTH,
    localparam int unsigned NL_W   = $clog2(NB_LOOPS) + 1,
    localparam int unsigned LOOP_W = $clog2(NB_LOOPS),
    localparam int unsigned ADDR_W = $clog2(LENGTH),
    localparam int unsigned NOPS_W = ADDR_W + 1,
    localparam int unsigned A_W    = $clog2(NB_REG),
    localparam int unsigned B_W    = $clog2(NB_REG + NB_RO_REG),
    localparam int unsigned CODE_W = 2 + A_W + B_W
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    input  logic                          start_i,
    input  logic [NL_W-1:0]               nb_loops_i,
    input  logic [NB_LOOPS*CNT_WIDTH-1:0] range_i,
    input  logic [NB_LOOPS*ADDR_W-1:0]    loop_addr_i,
    input  logic [NB_LOOPS*NOPS_W-1:0]    loop_nb_ops_i,
    input  logic [LENGTH*CODE_W-1:0]      code_i,
    input  logic [NB_RO_REG*REG_WIDTH-1:0] registers_read_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [NB_REG*REG_WIDTH-1:0]   out_offs_o,
    output logic [NB_LOOPS*CNT_WIDTH-1:0] out_idx_o,
    output logic [LOOP_W-1:0]             out_loop_o,
    output logic                          out_last_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int unsigned OFFS_W = NB_REG * REG_WIDTH;
    localparam int unsigned IDX_W  = NB_LOOPS * CNT_WIDTH;
    localparam int unsigned REC_W  = OFFS_W + IDX_W + LOOP_W + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [NOPS_W-1:0]    NOPS_ONE = NOPS_W'(1);

    uloop_state_t         state_q, state_d;
    logic [REG_WIDTH-1:0] regs_q [NB_REG];
    logic [REG_WIDTH-1:0] regs_d [NB_REG];
    logic [CNT_WIDTH-1:0] idx_q [NB_LOOPS];
    logic [CNT_WIDTH-1:0] idx_d [NB_LOOPS];
    logic [NOPS_W-1:0]    op_cnt_q, op_cnt_d;

    logic [CNT_WIDTH-1:0] range_eff [NB_LOOPS];
    logic [ADDR_W-1:0]    loop_addr [NB_LOOPS];
    logic [NOPS_W-1:0]    loop_nb_ops [NB_LOOPS];
    logic [CODE_W-1:0]    code_arr [LENGTH];
    logic [REG_WIDTH-1:0] ro_reg [NB_RO_REG];
    logic [NB_LOOPS-1:0]  active;

    logic [LOOP_W-1:0]    step_loop;
    logic [NOPS_W-1:0]    nb_ops;
    logic [ADDR_W-1:0]    code_addr;
    logic [CODE_W-1:0]    code_word;
    uloop_op_t            op;
    logic [A_W-1:0]       op_a;
    logic [B_W-1:0]       op_b;
    logic [REG_WIDTH-1:0] operand;
    logic [REG_WIDTH-1:0] regs_exec [NB_REG];
    logic [CNT_WIDTH-1:0] idx_next [NB_LOOPS];
    logic                 next_last, all_short, step_final;

    logic                 fifo_full, fifo_empty, push, pop, advance;
    logic                 rec_last;
    logic [LOOP_W-1:0]    rec_loop;
    logic [OFFS_W-1:0]    rec_offs;
    logic [IDX_W-1:0]     rec_idx;
    logic [REC_W-1:0]     push_data, head;

    always_comb begin
        for (int unsigned j = 0; j < NB_LOOPS; j++) begin
            range_eff[j]   = (range_i[j*CNT_WIDTH +: CNT_WIDTH] == '0) ? CNT_ONE
                                                                       : range_i[j*CNT_WIDTH +: CNT_WIDTH];
            loop_addr[j]   = loop_addr_i[j*ADDR_W +: ADDR_W];
            loop_nb_ops[j] = loop_nb_ops_i[j*NOPS_W +: NOPS_W];
            active[j]      = (j < 32'(nb_loops_i));
        end
        for (int unsigned k = 0; k < LENGTH; k++) begin
            code_arr[k] = code_i[k*CODE_W +: CODE_W];
        end
        for (int unsigned k = 0; k < NB_RO_REG; k++) begin
            ro_reg[k] = registers_read_i[k*REG_WIDTH +: REG_WIDTH];
        end
    end

    // Step select: descending scan so the lowest eligible loop wins.
    always_comb begin
        step_loop = '0;
        for (int unsigned j = NB_LOOPS; j > 0; j--) begin
            if (active[j-1] && (idx_q[j-1] < range_eff[j-1] - CNT_ONE)) begin
                step_loop = LOOP_W'(j - 1);
            end
        end
        nb_ops    = loop_nb_ops[step_loop];
        code_addr = loop_addr[step_loop] + op_cnt_q[ADDR_W-1:0];
        code_word = code_arr[code_addr];
        op        = uloop_op_t'(code_word[CODE_W-1 -: 2]);
        op_a      = code_word[B_W +: A_W];
        op_b      = code_word[B_W-1:0];
    end

    // Op executor: operands are always taken from the pre-write register state.
    always_comb begin
        operand = '0;
        for (int unsigned k = 0; k < NB_REG; k++) begin
            if (32'(op_b) == k) operand = regs_q[k];
        end
        for (int unsigned k = 0; k < NB_RO_REG; k++) begin
            if (32'(op_b) == NB_REG + k) operand = ro_reg[k];
        end
        regs_exec = regs_q;
        for (int unsigned k = 0; k < NB_REG; k++) begin
            if (32'(op_a) == k) begin
                case (op)
                    ULOOP_OP_MOV: regs_exec[k] = operand;
                    ULOOP_OP_ADD: regs_exec[k] = regs_q[k] + operand;
                    ULOOP_OP_SUB: regs_exec[k] = regs_q[k] - operand;
                    default:      regs_exec[k] = regs_q[k];
                endcase
            end
        end
    end

    always_comb begin
        next_last = 1'b1;
        all_short = 1'b1;
        for (int unsigned j = 0; j < NB_LOOPS; j++) begin
            if (j < 32'(step_loop))       idx_next[j] = '0;
            else if (j == 32'(step_loop)) idx_next[j] = idx_q[j] + CNT_ONE;
            else                          idx_next[j] = idx_q[j];
            if (active[j] && (idx_next[j] != range_eff[j] - CNT_ONE)) next_last = 1'b0;
            if (active[j] && (range_eff[j] != CNT_ONE))               all_short = 1'b0;
        end
    end

    assign pop     = !fifo_empty && out_ready_i;
    assign advance = !fifo_full || pop;

    always_comb begin
        state_d    = state_q;
        regs_d     = regs_q;
        idx_d      = idx_q;
        op_cnt_d   = op_cnt_q;
        push       = 1'b0;
        rec_last   = 1'b0;
        rec_loop   = '0;
        step_final = 1'b0;
        case (state_q)
            ULOOP_IDLE: begin
                if (start_i) begin
                    regs_d   = '{default: '0};
                    idx_d    = '{default: '0};
                    op_cnt_d = '0;
                    push     = 1'b1;
                    rec_last = all_short;
                    state_d  = all_short ? ULOOP_DRAIN : ULOOP_RUN;
                end
            end
            ULOOP_RUN: begin
                if (advance) begin
                    step_final = (nb_ops == '0) || (op_cnt_q == nb_ops - NOPS_ONE);
                    if (nb_ops != '0) regs_d = regs_exec;
                    if (step_final) begin
                        idx_d    = idx_next;
                        op_cnt_d = '0;
                        push     = 1'b1;
                        rec_last = next_last;
                        rec_loop = step_loop;
                        if (next_last) state_d = ULOOP_DRAIN;
                    end else begin
                        op_cnt_d = op_cnt_q + NOPS_ONE;
                    end
                end
            end
            ULOOP_DRAIN: begin
                if (pop && head[REC_W-1]) state_d = ULOOP_IDLE;
            end
            default: state_d = ULOOP_IDLE;
        endcase
        if (clear_i) begin
            state_d  = ULOOP_IDLE;
            regs_d   = '{default: '0};
            idx_d    = '{default: '0};
            op_cnt_d = '0;
            push     = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ULOOP_IDLE;
            regs_q   <= '{default: '0};
            idx_q    <= '{default: '0};
            op_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            regs_q   <= regs_d;
            idx_q    <= idx_d;
            op_cnt_q <= op_cnt_d;
        end
    end

    always_comb begin
        rec_offs = '0;
        rec_idx  = '0;
        for (int unsigned k = 0; k < NB_REG; k++) begin
            rec_offs[k*REG_WIDTH +: REG_WIDTH] = regs_d[k];
        end
        for (int unsigned j = 0; j < NB_LOOPS; j++) begin
            rec_idx[j*CNT_WIDTH +: CNT_WIDTH] = idx_d[j];
        end
        push_data = {rec_last, rec_loop, rec_idx, rec_offs};
    end

    hwpe_ctrl_uloop_rec_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        out_valid_o = !fifo_empty;
        busy_o      = (state_q != ULOOP_IDLE);
        done_o      = (state_q == ULOOP_DRAIN) && pop && head[REC_W-1] && !clear_i;
        out_offs_o  = fifo_empty ? '0 : head[0 +: OFFS_W];
        out_idx_o   = fifo_empty ? '0 : head[OFFS_W +: IDX_W];
        out_loop_o  = fifo_empty ? '0 : head[REC_W-2 -: LOOP_W];
        out_last_o  = fifo_empty ? 1'b0 : head[REC_W-1];
    end

endmodule
